// File: rtl/pit_8254_host_if.sv
// pit_8254_host_if
//   CPU-side I/O front end for a three-channel 8254 timer. Decodes 8-bit
//   I/O requests (offsets 0..2 = counter data, 3 = control word) into
//   one-cycle per-counter command strobes. Read-back commands are also
//   decoded here. Read data is returned on a separate valid/ready channel.
//
// Ports
//   clk, reset            system clock, asynchronous active-high reset
//   io_req_*              request channel (valid/ready, wr, addr[1:0], wdata[7:0])
//   io_rsp_*              read response channel (valid/ready, rdata[7:0])
//   cnt_data_in[7:0]      shared write/control data bus to all counters
//   cnt_set_control_mode, cnt_latch_count, cnt_latch_status,
//   cnt_write, cnt_read   3-bit one-cycle strobes, bit i -> counter i
//   cnt_data_out[23:0]    counter i read data on [8i+7:8i]
module pit_8254_host_if #(
    parameter logic [7:0] CTRL_READ_VALUE = 8'hFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        io_req_valid,
    output logic        io_req_ready,
    input  logic        io_req_wr,
    input  logic [1:0]  io_req_addr,
    input  logic [7:0]  io_req_wdata,
    output logic        io_rsp_valid,
    input  logic        io_rsp_ready,
    output logic [7:0]  io_rsp_rdata,
    output logic [7:0]  cnt_data_in,
    output logic [2:0]  cnt_set_control_mode,
    output logic [2:0]  cnt_latch_count,
    output logic [2:0]  cnt_latch_status,
    output logic [2:0]  cnt_write,
    output logic [2:0]  cnt_read,
    input  logic [23:0] cnt_data_out
);

    typedef enum logic [1:0] {IDLE, CAPTURE, RESP} state_t;

    state_t     state;
    logic [1:0] rd_addr;
    logic       accept;

    assign accept = io_req_valid & io_req_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                <= IDLE;
            rd_addr              <= 2'd0;
            // ready comes up on the first clock after reset release
            io_req_ready         <= 1'b0;
            io_rsp_valid         <= 1'b0;
            io_rsp_rdata         <= 8'h00;
            cnt_data_in          <= 8'h00;
            cnt_set_control_mode <= 3'b000;
            cnt_latch_count      <= 3'b000;
            cnt_latch_status     <= 3'b000;
            cnt_write            <= 3'b000;
            cnt_read             <= 3'b000;
        end else begin
            // strobes are single-cycle pulses unless re-armed below
            cnt_set_control_mode <= 3'b000;
            cnt_latch_count      <= 3'b000;
            cnt_latch_status     <= 3'b000;
            cnt_write            <= 3'b000;
            cnt_read             <= 3'b000;

            case (state)
                IDLE: begin
                    io_req_ready <= 1'b1;
                    if (accept) begin
                        if (io_req_wr) begin
                            // counters decode mode/rw/bcd from this bus too
                            cnt_data_in <= io_req_wdata;
                            if (io_req_addr != 2'd3) begin
                                cnt_write[io_req_addr] <= 1'b1;
                            end else if (io_req_wdata[7:6] != 2'd3) begin
                                if (io_req_wdata[5:4] == 2'd0)
                                    cnt_latch_count[io_req_wdata[7:6]] <= 1'b1;
                                else
                                    cnt_set_control_mode[io_req_wdata[7:6]] <= 1'b1;
                            end else begin
                                // read-back: d[5]/d[4] are active-low
                                // count/status enables, d[3:1] select counters
                                for (int i = 0; i < 3; i++) begin
                                    cnt_latch_count[i]  <= ~io_req_wdata[5] & io_req_wdata[i+1];
                                    cnt_latch_status[i] <= ~io_req_wdata[4] & io_req_wdata[i+1];
                                end
                            end
                        end else begin
                            rd_addr      <= io_req_addr;
                            io_req_ready <= 1'b0;
                            state        <= CAPTURE;
                            if (io_req_addr != 2'd3)
                                cnt_read[io_req_addr] <= 1'b1;
                        end
                    end
                end

                CAPTURE: begin
                    // sample during the read-strobe cycle, before the counter
                    // advances its byte pointer / latch on this edge
                    if (rd_addr == 2'd3)
                        io_rsp_rdata <= CTRL_READ_VALUE;
                    else
                        io_rsp_rdata <= cnt_data_out[{rd_addr, 3'b000} +: 8];
                    io_rsp_valid <= 1'b1;
                    state        <= RESP;
                end

                RESP: begin
                    if (io_rsp_ready) begin
                        io_rsp_valid <= 1'b0;
                        io_req_ready <= 1'b1;
                        state        <= IDLE;
                    end
                end

                default: begin
                    state        <= IDLE;
                    io_req_ready <= 1'b1;
                    io_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
